systolic_ctrl: RTL

Sequencer for the ROWS x COLS MAC systolic array. On a `start` command it selects the dataflow for the whole array, then runs these phases in order:
- loads stationary operands (weight-stationary) or clears accumulators (output-stationary);
- streams `k_len` operand vectors with per-row and per-column skew;
- drains the pipeline;
- in output-stationary mode, reads results back row by row.

It sits between the host command interface and the array plus its operand/result buffers.

---
 rtl/systolic_ctrl_if.sv | 45 ++++
 rtl/systolic_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/systolic_ctrl_if.sv
//------------------------------------------------------------------------------
// Module   : systolic_ctrl_if
// Brief    : Command and array-control bundle between host, systolic_ctrl and
//            the MAC array with its operand/result buffers.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface systolic_ctrl_if #(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int K_W  = 8
);
    localparam int c_aw = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic            start;
    logic            stat_df;
    logic [K_W-1:0]  k_len;
    logic            busy;
    logic            done;
    logic            stat_df_bit_out;
    logic [ROWS-1:0] stat_load_row;
    logic [c_aw-1:0] load_addr;
    logic            acc_clr;
    logic [K_W-1:0]  rd_addr;
    logic [ROWS-1:0] row_valid;
    logic [COLS-1:0] col_valid;
    logic            res_rd;
    logic [c_aw-1:0] res_row;
    logic [31:0]     busy_cycles;

    modport master (
        output start, stat_df, k_len,
        input  busy, done, stat_df_bit_out, stat_load_row, load_addr, acc_clr,
               rd_addr, row_valid, col_valid, res_rd, res_row, busy_cycles
    );

    modport slave (
        input  start, stat_df, k_len,
        output busy, done, stat_df_bit_out, stat_load_row, load_addr, acc_clr,
               rd_addr, row_valid, col_valid, res_rd, res_row, busy_cycles
    );
endinterface

`default_nettype wire

// File: rtl/systolic_ctrl.sv
//------------------------------------------------------------------------------
// Module   : systolic_ctrl
// Brief    : Phase sequencer (load/clear, skewed stream, drain, readback) for a
//            ROWS x COLS MAC systolic array. Optional busy-cycle counter is
//            built when SYSTOLIC_CTRL_PERF_CNT_EN is defined.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module systolic_ctrl #(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int K_W  = 8
) (
    input  wire logic      clk,
    input  wire logic      rst,
    systolic_ctrl_if.slave bus
);
    localparam int c_aw = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int c_pw = $clog2(ROWS + COLS + 1);
    localparam int c_sw = (ROWS > COLS) ? ROWS : COLS;
    localparam logic [c_pw-1:0] c_rows_last  = c_pw'(ROWS - 1);
    localparam logic [c_pw-1:0] c_drain_last = c_pw'(ROWS + COLS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_CLEAR  = 3'd2,
        S_STREAM = 3'd3,
        S_DRAIN  = 3'd4,
        S_READ   = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t          r_state;
    logic            r_stat_df;
    logic [K_W-1:0]  r_k_len;
    logic [K_W-1:0]  r_cnt;
    logic [c_pw-1:0] r_ph_cnt;
    logic            r_busy;
    logic            r_done;
    logic [ROWS-1:0] r_load_row;
    logic [c_aw-1:0] r_load_addr;
    logic            r_acc_clr;
    logic [K_W-1:0]  r_rd_addr;
    logic            r_issue;
    logic            r_res_rd;
    logic [c_aw-1:0] r_res_row;
    logic [c_sw-1:0] r_skew;

    // Every output is set on the edge that enters the cycle it belongs to, so
    // phase outputs line up exactly with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_stat_df   <= 1'b0;
            r_k_len     <= '0;
            r_cnt       <= '0;
            r_ph_cnt    <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_load_row  <= '0;
            r_load_addr <= '0;
            r_acc_clr   <= 1'b0;
            r_rd_addr   <= '0;
            r_issue     <= 1'b0;
            r_res_rd    <= 1'b0;
            r_res_row   <= '0;
        end else begin
            r_done      <= 1'b0;
            r_load_row  <= '0;
            r_load_addr <= '0;
            r_acc_clr   <= 1'b0;
            r_rd_addr   <= '0;
            r_issue     <= 1'b0;
            r_res_rd    <= 1'b0;
            r_res_row   <= '0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_busy <= 1'b1;
                        if (bus.k_len == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_stat_df <= bus.stat_df;
                            r_k_len   <= bus.k_len;
                            r_cnt     <= '0;
                            r_ph_cnt  <= '0;
                            if (bus.stat_df) begin
                                r_state    <= S_LOAD;
                                r_load_row <= ROWS'(1);
                            end else begin
                                r_state   <= S_CLEAR;
                                r_acc_clr <= 1'b1;
                            end
                        end
                    end
                end
                S_LOAD: begin
                    if (r_ph_cnt == c_rows_last) begin
                        r_state <= S_STREAM;
                        r_issue <= 1'b1;
                    end else begin
                        r_ph_cnt    <= r_ph_cnt + c_pw'(1);
                        r_load_row  <= r_load_row << 1;
                        r_load_addr <= c_aw'(r_ph_cnt + c_pw'(1));
                    end
                end
                S_CLEAR: begin
                    r_state <= S_STREAM;
                    r_issue <= 1'b1;
                end
                S_STREAM: begin
                    // Compare against k_len-1 so the full K_W range never wraps.
                    if (r_cnt == r_k_len - K_W'(1)) begin
                        r_state  <= S_DRAIN;
                        r_ph_cnt <= '0;
                    end else begin
                        r_cnt     <= r_cnt + K_W'(1);
                        r_rd_addr <= r_cnt + K_W'(1);
                        r_issue   <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (r_ph_cnt == c_drain_last) begin
                        r_ph_cnt <= '0;
                        if (r_stat_df) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state  <= S_READ;
                            r_res_rd <= 1'b1;
                        end
                    end else begin
                        r_ph_cnt <= r_ph_cnt + c_pw'(1);
                    end
                end
                S_READ: begin
                    if (r_ph_cnt == c_rows_last) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_ph_cnt  <= r_ph_cnt + c_pw'(1);
                        r_res_rd  <= 1'b1;
                        r_res_row <= c_aw'(r_ph_cnt + c_pw'(1));
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Skew chain: tap i is the issue strobe delayed i+1 cycles.
    generate
        for (genvar i = 0; i < c_sw; i++) begin : g_skew
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_skew[i] <= 1'b0;
                end else if (i == 0) begin
                    r_skew[i] <= r_issue;
                end else begin
                    r_skew[i] <= r_skew[(i > 0) ? i - 1 : 0];
                end
            end
        end
    endgenerate

`ifdef SYSTOLIC_CTRL_PERF_CNT_EN
    logic [31:0] r_busy_cycles;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy_cycles <= '0;
        end else if (r_busy && (r_busy_cycles != '1)) begin
            r_busy_cycles <= r_busy_cycles + 32'd1;
        end
    end

    assign bus.busy_cycles = r_busy_cycles;
`else
    assign bus.busy_cycles = '0;
`endif

    assign bus.busy            = r_busy;
    assign bus.done            = r_done;
    assign bus.stat_df_bit_out = r_stat_df;
    assign bus.stat_load_row   = r_load_row;
    assign bus.load_addr       = r_load_addr;
    assign bus.acc_clr         = r_acc_clr;
    assign bus.rd_addr         = r_rd_addr;
    assign bus.row_valid       = r_skew[ROWS-1:0];
    assign bus.col_valid       = r_skew[COLS-1:0];
    assign bus.res_rd          = r_res_rd;
    assign bus.res_row         = r_res_row;

endmodule

`default_nettype wire
